// File: rtl/vr16_pkg.sv
// Shared definitions for the 4-register datapath: widths, register encodings and
// the operand-fetch FSM state type.
package vr16_pkg;

  localparam int DATA_W   = 16;
  localparam int SEL_W    = 2;
  localparam int NUM_REGS = 1 << SEL_W;

  localparam logic [SEL_W-1:0] REG_A = 2'b00;
  localparam logic [SEL_W-1:0] REG_B = 2'b01;
  localparam logic [SEL_W-1:0] REG_C = 2'b10;
  localparam logic [SEL_W-1:0] REG_D = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } of_state_e;

  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus the two-source hazard lookup.
// Same-cycle writeback bypass of the hazard is enabled with OPERAND_FWD_EN.
module operand_fetch_scoreboard
  import vr16_pkg::*;
#(
  parameter int SEL_W_P = SEL_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W_P-1:0]        src_a_sel,
  input  logic [SEL_W_P-1:0]        src_b_sel,
  input  logic                      wb_enable,
  input  logic [SEL_W_P-1:0]        wb_sel,
  input  logic                      set_en,
  input  logic [SEL_W_P-1:0]        set_sel,
  output logic                      clr_a,
  output logic                      clr_b,
  output logic                      hazard,
  output logic [(2**SEL_W_P)-1:0]   busy
);

  logic [(2**SEL_W_P)-1:0] busy_q;
  logic [(2**SEL_W_P)-1:0] busy_d;

`ifdef OPERAND_FWD_EN
  always_comb begin
    clr_a = wb_enable && (wb_sel == src_a_sel);
    clr_b = wb_enable && (wb_sel == src_b_sel);
  end
`else
  always_comb begin
    clr_a = 1'b0;
    clr_b = 1'b0;
  end
`endif

  always_comb begin
    hazard = (busy_q[src_a_sel] && !clr_a) || (busy_q[src_b_sel] && !clr_b);
  end

  // Clear first, then set: a new writer issued in the same cycle its
  // predecessor lands keeps the register marked busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_enable) begin
      busy_d[wb_sel] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: selects source operands, stalls on scoreboard hazards and holds the
// operand packet in a one-deep output register. Optional bypass: OPERAND_FWD_EN.
module operand_fetch
  import vr16_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int SEL_W_P  = SEL_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [SEL_W_P-1:0]       src_a_sel,
  input  logic [SEL_W_P-1:0]       src_b_sel,
  input  logic [SEL_W_P-1:0]       dest_sel,
  input  logic                     writes_dest,
  input  logic [DATA_W_P-1:0]      reg_a_in,
  input  logic [DATA_W_P-1:0]      reg_b_in,
  input  logic [DATA_W_P-1:0]      reg_c_in,
  input  logic [DATA_W_P-1:0]      reg_d_in,
  input  logic                     wb_enable,
  input  logic [SEL_W_P-1:0]       wb_sel,
  input  logic [DATA_W_P-1:0]      wb_data,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [DATA_W_P-1:0]      op_a,
  output logic [DATA_W_P-1:0]      op_b,
  output logic [SEL_W_P-1:0]       op_dest,
  output logic                     op_writes,
  output logic [(2**SEL_W_P)-1:0]  busy,
  output of_state_e                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. instr_ready is combinational; op_valid and op_* are registered and stay
  // stable while op_valid is high and op_ready is low.

  of_state_e              state_q, state_d;
  logic                   op_valid_q, op_valid_d;
  logic [DATA_W_P-1:0]    op_a_q, op_a_d;
  logic [DATA_W_P-1:0]    op_b_q, op_b_d;
  logic [SEL_W_P-1:0]     op_dest_q, op_dest_d;
  logic                   op_writes_q, op_writes_d;

  logic                   hazard;
  logic                   clr_a;
  logic                   clr_b;
  logic                   accept;
  logic [DATA_W_P-1:0]    reg_sel_a;
  logic [DATA_W_P-1:0]    reg_sel_b;
  logic [DATA_W_P-1:0]    opnd_a;
  logic [DATA_W_P-1:0]    opnd_b;

  operand_fetch_scoreboard #(
    .SEL_W_P (SEL_W_P)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .src_a_sel (src_a_sel),
    .src_b_sel (src_b_sel),
    .wb_enable (wb_enable),
    .wb_sel    (wb_sel),
    .set_en    (accept && writes_dest),
    .set_sel   (dest_sel),
    .clr_a     (clr_a),
    .clr_b     (clr_b),
    .hazard    (hazard),
    .busy      (busy)
  );

  always_comb begin
    instr_ready = !hazard && ((state_q == EMPTY) || op_ready);
    accept      = instr_valid && instr_ready;
  end

  always_comb begin
    case (src_a_sel)
      REG_A:   reg_sel_a = reg_a_in;
      REG_B:   reg_sel_a = reg_b_in;
      REG_C:   reg_sel_a = reg_c_in;
      default: reg_sel_a = reg_d_in;
    endcase
    case (src_b_sel)
      REG_A:   reg_sel_b = reg_a_in;
      REG_B:   reg_sel_b = reg_b_in;
      REG_C:   reg_sel_b = reg_c_in;
      default: reg_sel_b = reg_d_in;
    endcase
  end

`ifdef OPERAND_FWD_EN
  always_comb begin
    opnd_a = clr_a ? wb_data : reg_sel_a;
    opnd_b = clr_b ? wb_data : reg_sel_b;
  end
`else
  // Without bypass the register inputs already carry written data one cycle later.
  logic unused_wb_data;
  always_comb begin
    opnd_a         = reg_sel_a;
    opnd_b         = reg_sel_b;
    unused_wb_data = ^{wb_data, clr_a, clr_b};
  end
`endif

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_dest_d   = op_dest_q;
    op_writes_d = op_writes_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (op_ready && !accept) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      op_a_d      = opnd_a;
      op_b_d      = opnd_b;
      op_dest_d   = dest_sel;
      op_writes_d = writes_dest;
    end
    op_valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_dest_q   <= '0;
      op_writes_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_dest_q   <= op_dest_d;
      op_writes_q <= op_writes_d;
    end
  end

  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_dest   = op_dest_q;
  assign op_writes = op_writes_q;
  assign dbg_state = state_q;

endmodule
